// File: rtl/lsq_execution_unit_if.sv
// Command, result and D-cache port bundle of the load/store execution unit.
// The unit itself connects through the slave modport; the issue/cache side uses master.
interface lsq_execution_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SQ_DEPTH   = 4
);
    logic                          i_valid;
    logic                          i_access;
    logic [1:0]                    i_size;
    logic                          i_signed;
    logic [ADDR_WIDTH-1:0]         i_op1;
    logic [ADDR_WIDTH-1:0]         i_op2;
    logic [DATA_WIDTH-1:0]         i_data;
    logic                          o_done;
    logic [DATA_WIDTH-1:0]         o_result_data;
    logic                          o_misaligned;
    logic [$clog2(SQ_DEPTH+1)-1:0] o_sq_count;
    logic                          o_dc_valid;
    logic                          o_dc_write;
    logic [ADDR_WIDTH-1:0]         o_dc_addr;
    logic [DATA_WIDTH-1:0]         o_dc_data;
    logic [3:0]                    o_dc_be;
    logic                          i_dc_ready;
    logic                          i_dc_rvalid;
    logic [DATA_WIDTH-1:0]         i_dc_rdata;

    modport slave (
        input  i_valid, i_access, i_size, i_signed, i_op1, i_op2, i_data,
        input  i_dc_ready, i_dc_rvalid, i_dc_rdata,
        output o_done, o_result_data, o_misaligned, o_sq_count,
        output o_dc_valid, o_dc_write, o_dc_addr, o_dc_data, o_dc_be
    );

    modport master (
        output i_valid, i_access, i_size, i_signed, i_op1, i_op2, i_data,
        output i_dc_ready, i_dc_rvalid, i_dc_rdata,
        input  o_done, o_result_data, o_misaligned, o_sq_count,
        input  o_dc_valid, o_dc_write, o_dc_addr, o_dc_data, o_dc_be
    );
endinterface

// File: rtl/lsq_execution_unit.sv
// Load/store execution stage with an in-order store queue that drains to the D-cache
// in the background and forwards youngest-store data to loads.
module lsq_execution_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SQ_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    lsq_execution_unit_if.slave bus
);
    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = $clog2(SQ_DEPTH + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] sq_addr_q [SQ_DEPTH];
    logic [ADDR_WIDTH-1:0] sq_addr_d [SQ_DEPTH];
    logic [DATA_WIDTH-1:0] sq_data_q [SQ_DEPTH];
    logic [DATA_WIDTH-1:0] sq_data_d [SQ_DEPTH];
    logic [3:0]            sq_be_q   [SQ_DEPTH];
    logic [3:0]            sq_be_d   [SQ_DEPTH];
    logic [1:0]            ld_off_q, ld_off_d, ld_size_q, ld_size_d;
    logic                  ld_signed_q, ld_signed_d;

    logic [ADDR_WIDTH-1:0] ea, ea_word;
    logic [3:0]            need;
    logic                  misaligned;
    logic                  fwd_hit, fwd_full;
    logic [3:0]            fwd_be;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PTR_W-1:0]      fwd_idx;
    logic                  load_port, enq, pop;

    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] word,
                                                      input logic [1:0] off,
                                                      input logic [1:0] size,
                                                      input logic       sgn);
        logic [DATA_WIDTH-1:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    extract = sgn ? {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]}
                                   : {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            2'd1:    extract = sgn ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]}
                                   : {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: extract = sh;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [3:0] be);
        lane_mask = DATA_WIDTH'({{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}});
    endfunction

    assign ea         = bus.i_op1 + bus.i_op2;
    assign ea_word    = {ea[ADDR_WIDTH-1:2], 2'b00};
    assign misaligned = ((bus.i_size == 2'd1) && ea[0]) || (bus.i_size[1] && (ea[1:0] != 2'b00));

    always_comb begin
        case (bus.i_size)
            2'd0:    need = 4'b0001 << ea[1:0];
            2'd1:    need = 4'b0011 << ea[1:0];
            default: need = 4'b1111;
        endcase
    end

    // Walk oldest to youngest so the last match left standing is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_be   = 4'b0000;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (sq_addr_q[fwd_idx] == ea_word) &&
                ((sq_be_q[fwd_idx] & need) != 4'b0000)) begin
                fwd_hit  = 1'b1;
                fwd_be   = sq_be_q[fwd_idx];
                fwd_data = sq_data_q[fwd_idx];
            end
        end
        fwd_full = fwd_hit && ((fwd_be & need) == need);
    end

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        sq_addr_d   = sq_addr_q;
        sq_data_d   = sq_data_q;
        sq_be_d     = sq_be_q;
        ld_off_d    = ld_off_q;
        ld_size_d   = ld_size_q;
        ld_signed_d = ld_signed_q;
        load_port   = 1'b0;
        enq         = 1'b0;
        pop         = 1'b0;
        bus.o_done        = 1'b0;
        bus.o_misaligned  = 1'b0;
        bus.o_result_data = '0;
        bus.o_dc_valid    = 1'b0;
        bus.o_dc_write    = 1'b0;
        bus.o_dc_addr     = '0;
        bus.o_dc_data     = '0;
        bus.o_dc_be       = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    if (misaligned) begin
                        bus.o_done       = 1'b1;
                        bus.o_misaligned = 1'b1;
                    end else if (bus.i_access) begin
                        // A full queue never accepts, so the tail can't collide with a popping head.
                        if (count_q < CNT_W'(SQ_DEPTH)) begin
                            enq        = 1'b1;
                            bus.o_done = 1'b1;
                        end
                    end else if (fwd_full) begin
                        bus.o_done        = 1'b1;
                        bus.o_result_data = extract(fwd_data, ea[1:0], bus.i_size, bus.i_signed);
                    end else if (!fwd_hit) begin
                        load_port      = 1'b1;
                        bus.o_dc_valid = 1'b1;
                        bus.o_dc_addr  = ea_word;
                        if (bus.i_dc_ready) begin
                            state_d     = S_WAIT;
                            ld_off_d    = ea[1:0];
                            ld_size_d   = bus.i_size;
                            ld_signed_d = bus.i_signed;
                        end
                    end
                end
            end
            S_WAIT: begin
                load_port = 1'b1;
                if (bus.i_dc_rvalid) begin
                    bus.o_done        = 1'b1;
                    bus.o_result_data = extract(bus.i_dc_rdata, ld_off_q, ld_size_q, ld_signed_q);
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Background drain uses the port whenever a load does not.
        if (!load_port && (count_q != '0)) begin
            bus.o_dc_valid = 1'b1;
            bus.o_dc_write = 1'b1;
            bus.o_dc_addr  = sq_addr_q[head_q];
            bus.o_dc_data  = sq_data_q[head_q];
            bus.o_dc_be    = sq_be_q[head_q];
            pop            = bus.i_dc_ready;
        end

        if (enq) begin
            sq_addr_d[tail_q] = ea_word;
            sq_data_d[tail_q] = (bus.i_data << {ea[1:0], 3'b000}) & lane_mask(need);
            sq_be_d[tail_q]   = need;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign bus.o_sq_count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads and latched load attributes are only meaningful behind valid control state.
    always_ff @(posedge clk) begin
        sq_addr_q   <= sq_addr_d;
        sq_data_q   <= sq_data_d;
        sq_be_q     <= sq_be_d;
        ld_off_q    <= ld_off_d;
        ld_size_q   <= ld_size_d;
        ld_signed_q <= ld_signed_d;
    end
endmodule
